// File: rtl/vec_execute_stage_pkg.sv
// vexe_pkg: shared types and helpers for the vector execute stage.
//   op_e    : 4-bit ALU opcode carried on alu_ctrl
//   state_e : multi-cycle FSM state
//   DEF_*   : default lane geometry
//   cnt_w() : width of the multiply iteration counter
package vexe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_ROTL = 4'd7,
    OP_MUL  = 4'd8,
    OP_BCST = 4'd9,
    OP_CMP  = 4'd10,
    OP_PASS = 4'd11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DEF_LANES   = 4;
  localparam int DEF_DW      = 32;
  localparam int DEF_RW      = 4;
  localparam int DEF_MUL_LAT = 4;

  // The counter must exist even when the multiply is single-cycle.
  function automatic int cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/vec_execute_stage_if.sv
// vexe_if: operand/handshake bundle between the decode stage (master)
// and the execute stage (slave), including the registered EXE/MEM outputs.
//   in_valid/in_ready            : operation handshake
//   reg_write_e/mem_write_e      : control in
//   alu_ctrl, column, rdest_in   : opcode, broadcast lane, destination
//   src_a/src_b                  : lane i operand at [i*DW +: DW]
//   out_valid, reg_write_m, mem_write_m, rd_m, result, cmp_mask, zero_flag
//                                : registered outputs
interface vexe_if #(
  parameter int LANES = 4,
  parameter int DW    = 32,
  parameter int RW    = 4
) ();
  import vexe_pkg::*;

  localparam int SW = $clog2(LANES);

  logic                  in_valid;
  logic                  in_ready;
  logic                  reg_write_e;
  logic                  mem_write_e;
  op_e                   alu_ctrl;
  logic [SW-1:0]         column;
  logic [RW-1:0]         rdest_in;
  logic [LANES*DW-1:0]   src_a;
  logic [LANES*DW-1:0]   src_b;
  logic                  out_valid;
  logic                  reg_write_m;
  logic                  mem_write_m;
  logic [RW-1:0]         rd_m;
  logic [LANES*DW-1:0]   result;
  logic [LANES-1:0]      cmp_mask;
  logic                  zero_flag;

  modport master (
    output in_valid, reg_write_e, mem_write_e, alu_ctrl, column, rdest_in,
           src_a, src_b,
    input  in_ready, out_valid, reg_write_m, mem_write_m, rd_m, result,
           cmp_mask, zero_flag
  );

  modport slave (
    input  in_valid, reg_write_e, mem_write_e, alu_ctrl, column, rdest_in,
           src_a, src_b,
    output in_ready, out_valid, reg_write_m, mem_write_m, rd_m, result,
           cmp_mask, zero_flag
  );

endinterface

// File: rtl/vec_execute_stage_lane.sv
// vexe_lane: one lane of the execute stage.
//   Combinational ALU (alu_res, cmp_bit) plus the shift-add multiply slice
//   that retires DW/MUL_LAT multiplier bits per step.
//   clk, rst (sync, active-low), load (latch operands), step (one iteration)
//   op, a, b, bcst (broadcast operand) -> alu_res, cmp_bit, mul_res
//   mul_res is the accumulator after the current step, so the final step's
//   product can be registered by the top on the same edge.
module vexe_lane
  import vexe_pkg::*;
#(
  parameter int DW      = 32,
  parameter int MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  op_e           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] bcst,
  output logic [DW-1:0] alu_res,
  output logic          cmp_bit,
  output logic [DW-1:0] mul_res
);

  localparam int K   = DW / MUL_LAT;
  localparam int SHW = $clog2(DW);

  logic [DW-1:0]   acc, ma, mb;
  logic [SHW-1:0]  sh;
  logic [2*DW-1:0] rot;

  // Partial product of the low K multiplier bits.
  function automatic logic [DW-1:0] partial(input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
    logic [DW-1:0] s;
    s = '0;
    for (int j = 0; j < K; j++)
      if (y[j]) s = s + (x << j);
    return s;
  endfunction

  assign sh      = b[SHW-1:0];
  assign rot     = {a, a} << sh;
  assign mul_res = acc + partial(ma, mb);

  always_comb begin
    alu_res = a;
    cmp_bit = 1'b0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  alu_res = a << sh;
      OP_SHR:  alu_res = a >> sh;
      OP_ROTL: alu_res = rot[2*DW-1:DW];
      // Full product only when K == DW; otherwise the top takes the
      // iterative path and ignores this value.
      OP_MUL:  alu_res = partial(a, b);
      OP_BCST: alu_res = bcst;
      OP_CMP: begin
        alu_res = '0;
        cmp_bit = (a == b);
      end
      default: alu_res = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      ma  <= '0;
      mb  <= '0;
    end else if (load) begin
      acc <= '0;
      ma  <= a;
      mb  <= b;
    end else if (step) begin
      acc <= mul_res;
      ma  <= ma << K;
      mb  <= mb >> K;
    end
  end

endmodule

// File: rtl/vec_execute_stage.sv
// vec_execute_stage: LANES-wide execute stage with registered EXE/MEM output.
//   clk, rst (sync, active-low), stop (global stall), flush (discard)
//   bus : vexe_if.slave carrying handshake, operands and registered outputs
// Optional: VEXE_PERF_CNT_EN adds perf_ops / perf_stall / perf_flush
//   (32-bit wrapping counters of accepts, stalled offers and flush cycles).
//
// state | meaning
// IDLE  | ready for a new op; single-cycle ops register on the accept edge
// BUSY  | iterative multiply running, cnt counts down to the final step
module vec_execute_stage
  import vexe_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int DW      = DEF_DW,
  parameter int RW      = DEF_RW,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stop,
  input  logic        flush,
  vexe_if.slave       bus
`ifdef VEXE_PERF_CNT_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam int CW = cnt_w(MUL_LAT);

  state_e              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                accept, is_mul, mul_load, mul_step, load_out, use_mul;
  logic                rw_l, mw_l;
  logic [RW-1:0]       rd_l;
  logic [DW-1:0]       a_lane [LANES];
  logic [DW-1:0]       bcst_val;
  logic [LANES*DW-1:0] alu_res, mul_res;
  logic [LANES-1:0]    cmp_bits;

  assign bus.in_ready = (state == IDLE) && !stop;
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign is_mul       = (bus.alu_ctrl == OP_MUL) && (MUL_LAT > 1);
  assign mul_load     = accept && is_mul;
  assign mul_step     = (state == BUSY) && !stop && !flush;
  assign bcst_val     = a_lane[bus.column];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign a_lane[i] = bus.src_a[i*DW +: DW];

    vexe_lane #(.DW(DW), .MUL_LAT(MUL_LAT)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (mul_load),
      .step    (mul_step),
      .op      (bus.alu_ctrl),
      .a       (bus.src_a[i*DW +: DW]),
      .b       (bus.src_b[i*DW +: DW]),
      .bcst    (bcst_val),
      .alu_res (alu_res[i*DW +: DW]),
      .cmp_bit (cmp_bits[i]),
      .mul_res (mul_res[i*DW +: DW])
    );
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    load_out = 1'b0;
    use_mul  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_n = BUSY;
            cnt_n   = CW'(MUL_LAT - 1);
          end else begin
            load_out = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_n  = IDLE;
          load_out = 1'b1;
          use_mul  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rw_l            <= 1'b0;
      mw_l            <= 1'b0;
      rd_l            <= '0;
      bus.out_valid   <= 1'b0;
      bus.reg_write_m <= 1'b0;
      bus.mem_write_m <= 1'b0;
      bus.rd_m        <= '0;
      bus.result      <= '0;
      bus.cmp_mask    <= '0;
      bus.zero_flag   <= 1'b0;
    end else if (flush) begin
      // Data fields keep their last values; only the qualifiers drop.
      state           <= IDLE;
      cnt             <= '0;
      bus.out_valid   <= 1'b0;
      bus.reg_write_m <= 1'b0;
      bus.mem_write_m <= 1'b0;
    end else if (!stop) begin
      state         <= state_n;
      cnt           <= cnt_n;
      bus.out_valid <= load_out;
      if (mul_load) begin
        rw_l <= bus.reg_write_e;
        mw_l <= bus.mem_write_e;
        rd_l <= bus.rdest_in;
      end
      if (load_out) begin
        if (use_mul) begin
          bus.reg_write_m <= rw_l;
          bus.mem_write_m <= mw_l;
          bus.rd_m        <= rd_l;
          bus.result      <= mul_res;
          bus.cmp_mask    <= '0;
          bus.zero_flag   <= 1'b0;
        end else begin
          bus.reg_write_m <= bus.reg_write_e;
          bus.mem_write_m <= bus.mem_write_e;
          bus.rd_m        <= bus.rdest_in;
          bus.result      <= alu_res;
          bus.cmp_mask    <= cmp_bits;
          bus.zero_flag   <= &cmp_bits;
        end
      end
    end
  end

`ifdef VEXE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (accept)                          perf_ops   <= perf_ops + 32'd1;
      if (bus.in_valid && !bus.in_ready)   perf_stall <= perf_stall + 32'd1;
      if (flush)                           perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_execute_stage.sv
module tb_vec_execute_stage;
  import vexe_pkg::*;

  logic clk = 1'b0;
  logic rst, stop, flush;
  int   errors = 0;
  int   checks = 0;

`ifdef VEXE_PERF_CNT_EN
  logic [31:0] perf_ops, perf_stall, perf_flush;
`endif

  vexe_if #(.LANES(4), .DW(32), .RW(4)) bus ();

  vec_execute_stage #(.LANES(4), .DW(32), .RW(4), .MUL_LAT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .stop  (stop),
    .flush (flush),
    .bus   (bus)
`ifdef VEXE_PERF_CNT_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rep(input logic [31:0] x);
    return {4{x}};
  endfunction

  task automatic drive(input op_e op, input logic [127:0] a,
                       input logic [127:0] b, input logic [1:0] col,
                       input logic [3:0] rd, input logic rw, input logic mw);
    bus.in_valid    = 1'b1;
    bus.alu_ctrl    = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.column      = col;
    bus.rdest_in    = rd;
    bus.reg_write_e = rw;
    bus.mem_write_e = mw;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic op1(input string tag, input op_e op, input logic [127:0] a,
                     input logic [127:0] b, input logic [1:0] col,
                     input logic [127:0] exp_res, input logic [3:0] exp_cmp,
                     input logic exp_zf);
    drive(op, a, b, col, 4'h3, 1'b1, 1'b0);
    tick();
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_res"}, bus.result, exp_res);
    check({tag, "_cmp"}, bus.cmp_mask, exp_cmp);
    check({tag, "_zf"}, bus.zero_flag, exp_zf);
  endtask

  initial begin
    rst = 1'b0; stop = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.reg_write_e = 1'b0; bus.mem_write_e = 1'b0;
    bus.alu_ctrl = OP_PASS; bus.column = '0; bus.rdest_in = '0;
    bus.src_a = '0; bus.src_b = '0;

    // reset
    tick(); tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_cmp", bus.cmp_mask, 0);
    check("rst_zf", bus.zero_flag, 0);
    check("rst_rd", bus.rd_m, 0);
    check("rst_rw", bus.reg_write_m, 0);
    check("rst_mw", bus.mem_write_m, 0);
    check("rst_ready", bus.in_ready, 1);
    rst = 1'b1;

    // ADD wraps
    drive(OP_ADD, rep(32'hFFFFFFFF), rep(32'd2), 2'd0, 4'd5, 1'b1, 1'b0);
    check("add_pre_valid", bus.out_valid, 0);
    tick(); idle();
    check("add_valid", bus.out_valid, 1);
    check("add_res", bus.result, rep(32'd1));
    check("add_rd", bus.rd_m, 5);
    check("add_rw", bus.reg_write_m, 1);
    check("add_cmp", bus.cmp_mask, 0);
    tick();
    check("add_hold_valid", bus.out_valid, 0);
    check("add_hold_res", bus.result, rep(32'd1));

    // back-to-back single-cycle ops
    drive(OP_SUB, rep(32'd5), rep(32'd7), 2'd0, 4'd6, 1'b1, 1'b1);
    tick();
    check("sub_valid", bus.out_valid, 1);
    check("sub_res", bus.result, rep(32'hFFFFFFFE));
    check("sub_mw", bus.mem_write_m, 1);
    drive(OP_XOR, rep(32'hF0F0F0F0), rep(32'hFF00FF00), 2'd0, 4'd7, 1'b0, 1'b0);
    tick();
    check("xor_valid", bus.out_valid, 1);
    check("xor_res", bus.result, rep(32'h0FF00FF0));
    check("xor_rw", bus.reg_write_m, 0);
    check("xor_rd", bus.rd_m, 7);
    op1("and", OP_AND, rep(32'hF0F0F0F0), rep(32'hFF00FF00), 2'd0, rep(32'hF000F000), 4'b0, 1'b0);
    op1("or", OP_OR, rep(32'hF0F0F0F0), rep(32'hFF00FF00), 2'd0, rep(32'hFFF0FFF0), 4'b0, 1'b0);
    op1("shl", OP_SHL, rep(32'd1), rep(32'h24), 2'd0, rep(32'h10), 4'b0, 1'b0);
    op1("shr", OP_SHR, rep(32'h80000000), rep(32'd31), 2'd0, rep(32'd1), 4'b0, 1'b0);
    op1("rotl", OP_ROTL, rep(32'h80000001), rep(32'd1), 2'd0, rep(32'd3), 4'b0, 1'b0);
    op1("bcst", OP_BCST, {32'd4, 32'hABCD, 32'd2, 32'd1}, '0, 2'd2, rep(32'hABCD), 4'b0, 1'b0);
    op1("cmp2", OP_CMP, {32'd9, 32'd8, 32'd7, 32'd6}, {32'd9, 32'd0, 32'd0, 32'd6}, 2'd0, '0, 4'b1001, 1'b0);
    op1("cmp4", OP_CMP, rep(32'd3), rep(32'd3), 2'd0, '0, 4'b1111, 1'b1);
    op1("undef", op_e'(4'hF), {32'd1, 32'd2, 32'd3, 32'd4}, rep(32'd9), 2'd0, {32'd1, 32'd2, 32'd3, 32'd4}, 4'b0, 1'b0);
    idle(); tick();
    check("idle_valid", bus.out_valid, 0);

    // MUL latency
    drive(OP_MUL, {32'h10000, 32'd3, 32'hFFFFFFFF, 32'd7},
          {32'h10000, 32'd5, 32'd2, 32'd6}, 2'd0, 4'd9, 1'b1, 1'b0);
    tick(); idle();
    for (int k = 0; k < 4; k++) begin
      check("mul_busy_ready", bus.in_ready, 0);
      check("mul_busy_valid", bus.out_valid, 0);
      tick();
    end
    check("mul_valid", bus.out_valid, 1);
    check("mul_res", bus.result, {32'd0, 32'd15, 32'hFFFFFFFE, 32'd42});
    check("mul_rd", bus.rd_m, 9);
    check("mul_rw", bus.reg_write_m, 1);
    check("mul_cmp", bus.cmp_mask, 0);
    check("mul_ready", bus.in_ready, 1);

    // stop holds a valid output and blocks accepts
    drive(OP_ADD, rep(32'd1), rep(32'd1), 2'd0, 4'd2, 1'b1, 1'b0);
    tick();
    drive(OP_ADD, rep(32'd100), rep(32'd1), 2'd0, 4'd2, 1'b1, 1'b0);
    stop = 1'b1;
    #1;
    check("stop_ready", bus.in_ready, 0);
    tick();
    check("stop_hold_valid", bus.out_valid, 1);
    check("stop_hold_res", bus.result, rep(32'd2));
    idle(); stop = 1'b0;
    tick();
    check("stop_rel_valid", bus.out_valid, 0);
    check("stop_rel_res", bus.result, rep(32'd2));

    // stop for 3 cycles mid-MUL (cnt=2)
    drive(OP_MUL, rep(32'h1234), rep(32'h10), 2'd0, 4'd1, 1'b1, 1'b0);
    tick(); idle();
    tick();
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("mstop_ready", bus.in_ready, 0);
      check("mstop_valid", bus.out_valid, 0);
      check("mstop_res", bus.result, rep(32'd2));
      tick();
    end
    stop = 1'b0;
    tick();
    check("mstop_cnt1_valid", bus.out_valid, 0);
    tick();
    check("mstop_cnt0_valid", bus.out_valid, 0);
    tick();
    check("mstop_valid", bus.out_valid, 1);
    check("mstop_res_done", bus.result, rep(32'h12340));

    // flush with a valid output and a same-cycle offer
    drive(OP_ADD, rep(32'd10), rep(32'd20), 2'd0, 4'd4, 1'b1, 1'b1);
    tick();
    check("pre_flush_res", bus.result, rep(32'd30));
    flush = 1'b1;
    drive(OP_ADD, rep(32'd1), rep(32'd1), 2'd0, 4'd4, 1'b1, 1'b1);
    tick();
    flush = 1'b0; idle();
    check("flush_valid", bus.out_valid, 0);
    check("flush_rw", bus.reg_write_m, 0);
    check("flush_mw", bus.mem_write_m, 0);
    check("flush_res_hold", bus.result, rep(32'd30));
    check("flush_ready", bus.in_ready, 1);
    tick();
    check("flush_drop_valid", bus.out_valid, 0);
    check("flush_drop_res", bus.result, rep(32'd30));

    // flush while BUSY, together with stop
    drive(OP_MUL, rep(32'd7), rep(32'd7), 2'd0, 4'd8, 1'b1, 1'b0);
    tick(); idle();
    tick();
    flush = 1'b1; stop = 1'b1;
    tick();
    flush = 1'b0; stop = 1'b0;
    #1;
    check("bflush_ready", bus.in_ready, 1);
    check("bflush_valid", bus.out_valid, 0);
    drive(OP_ADD, rep(32'd5), rep(32'd6), 2'd0, 4'd8, 1'b1, 1'b0);
    tick(); idle();
    check("bflush_add_valid", bus.out_valid, 1);
    check("bflush_add_res", bus.result, rep(32'd11));
    for (int k = 0; k < 6; k++) begin
      tick();
      check("bflush_no_stale_valid", bus.out_valid, 0);
      check("bflush_no_stale_res", bus.result, rep(32'd11));
    end

    // reset mid-MUL at cnt=1
    drive(OP_MUL, rep(32'd3), rep(32'd3), 2'd0, 4'd6, 1'b1, 1'b1);
    tick(); idle();
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rmul_valid", bus.out_valid, 0);
    check("rmul_res", bus.result, 0);
    check("rmul_rd", bus.rd_m, 0);
    check("rmul_rw", bus.reg_write_m, 0);
    check("rmul_ready", bus.in_ready, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rmul_no_stale_valid", bus.out_valid, 0);
      check("rmul_no_stale_res", bus.result, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
